// File: rtl/inst_mem_arbiter_if.sv
// Bus bundle joining the two fetch masters, the arbiter and the instruction memory.
// The slave view belongs to the arbiter; the master view drives the arbiter's inputs.
interface inst_mem_arbiter_if;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_ack_o;
    logic        m0_error_o;
    logic [31:0] m0_data_o;
    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic        m1_ack_o;
    logic        m1_error_o;
    logic [31:0] m1_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic        mem_error_i;
    logic [31:0] mem_data_i;
    logic        busy_o;
    logic        gnt_id_o;

    modport slave (
        input  m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
        input  mem_ack_i, mem_error_i, mem_data_i,
        output m0_ack_o, m0_error_o, m0_data_o,
        output m1_ack_o, m1_error_o, m1_data_o,
        output mem_req_o, mem_addr_o, busy_o, gnt_id_o
    );

    modport master (
        output m0_req_i, m0_addr_i, m1_req_i, m1_addr_i,
        output mem_ack_i, mem_error_i, mem_data_i,
        input  m0_ack_o, m0_error_o, m0_data_o,
        input  m1_ack_o, m1_error_o, m1_data_o,
        input  mem_req_o, mem_addr_o, busy_o, gnt_id_o
    );
endinterface

// File: rtl/inst_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between two fetch masters,
// locking the port per transaction and closing hung transactions with a timeout error.
module inst_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    inst_mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic               r_gnt_id;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic [CNT_W-1:0]   r_tmo_cnt;

    logic               w_grant;
    logic               w_gnt_sel;
    logic               w_mem_ack;
    logic               w_timeout;
    logic               w_resp;
    logic               w_resp_err;
    logic [31:0]        w_resp_data;
    logic               w_to_m0;
    logic               w_to_m1;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_sel   = r_prio;
        w_mem_ack   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.m0_req_i && bus.m1_req_i) w_gnt_sel = r_prio;
                else                              w_gnt_sel = bus.m1_req_i;
                w_grant = bus.m0_req_i || bus.m1_req_i;
                if (w_grant) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                w_mem_ack = bus.mem_ack_i;
                w_timeout = (TIMEOUT_CYCLES != 0) && !bus.mem_ack_i
                            && (r_tmo_cnt == CNT_W'(TMO_LAST));
                if (w_mem_ack || w_timeout) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Responses are suppressed while reset is held so an abandoned transaction stays silent.
        w_resp      = !rst_i && (w_mem_ack || w_timeout);
        w_resp_err  = w_mem_ack ? bus.mem_error_i : 1'b1;
        w_resp_data = w_mem_ack ? bus.mem_data_i  : 32'h0;
        w_to_m0     = w_resp && !r_gnt_id;
        w_to_m1     = w_resp &&  r_gnt_id;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio     <= 1'b0;
            r_gnt_id   <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_tmo_cnt  <= '0;
        end else if (w_grant) begin
            r_gnt_id   <= w_gnt_sel;
            r_prio     <= ~w_gnt_sel;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_gnt_sel ? bus.m1_addr_i : bus.m0_addr_i;
            r_tmo_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            if (w_state_nxt == S_IDLE) r_mem_req <= 1'b0;
            else                       r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    assign bus.m0_ack_o   = w_to_m0;
    assign bus.m0_error_o = w_to_m0 && w_resp_err;
    assign bus.m0_data_o  = w_to_m0 ? w_resp_data : 32'h0;
    assign bus.m1_ack_o   = w_to_m1;
    assign bus.m1_error_o = w_to_m1 && w_resp_err;
    assign bus.m1_data_o  = w_to_m1 ? w_resp_data : 32'h0;
    assign bus.mem_req_o  = r_mem_req;
    assign bus.mem_addr_o = r_mem_addr;
    assign bus.busy_o     = (r_state == S_BUSY);
    assign bus.gnt_id_o   = r_gnt_id;
endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter: a cycle table, hand-written timeout and
// reset sequences, then random traffic against a transaction-level reference model.
module tb_inst_mem_arbiter;
    localparam int TMO = 4;
    localparam logic [31:0] A_M0 = 32'h1000_0000;
    localparam logic [31:0] A_M1 = 32'h2000_0004;
    localparam logic [31:0] A_S  = 32'h8000_0010;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    inst_mem_arbiter_if bus();

    inst_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic        ack;
        logic        err;
        logic [31:0] data;
        logic        e_mr;
        logic        e_gnt;
        logic [31:0] e_addr;
        logic        e_a0;
        logic        e_a1;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t v(logic rst, logic r0, logic [31:0] a0, logic r1, logic ack,
                               logic err, logic [31:0] data, logic e_mr, logic e_gnt,
                               logic [31:0] e_addr, logic e_a0, logic e_a1, logic e_err,
                               logic [31:0] e_data);
        vec_t t;
        t = '{rst, r0, a0, r1, ack, err, data, e_mr, e_gnt, e_addr, e_a0, e_a1, e_err, e_data};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs change 1 unit after the edge, outputs are sampled 3 units later.
    task automatic cycle(input logic rst, input logic r0, input logic [31:0] a0, input logic r1,
                         input logic [31:0] a1, input logic ack, input logic err,
                         input logic [31:0] data);
        @(posedge clk_i);
        #1;
        rst_i           = rst;
        bus.m0_req_i    = r0;
        bus.m0_addr_i   = a0;
        bus.m1_req_i    = r1;
        bus.m1_addr_i   = a1;
        bus.mem_ack_i   = ack;
        bus.mem_error_i = err;
        bus.mem_data_i  = data;
        #3;
    endtask

    task automatic check_outs(input string tag, input logic e_mr, input logic e_gnt,
                              input logic [31:0] e_addr, input logic e_a0, input logic e_a1,
                              input logic e_err, input logic [31:0] e_data);
        check({tag, ".mem_req"}, 32'(bus.mem_req_o), 32'(e_mr));
        check({tag, ".busy"},    32'(bus.busy_o),    32'(e_mr));
        check({tag, ".gnt_id"},  32'(bus.gnt_id_o),  32'(e_gnt));
        if (e_mr) check({tag, ".mem_addr"}, bus.mem_addr_o, e_addr);
        check({tag, ".m0_ack"},  32'(bus.m0_ack_o),   32'(e_a0));
        check({tag, ".m0_err"},  32'(bus.m0_error_o), 32'(e_a0 && e_err));
        check({tag, ".m0_data"}, bus.m0_data_o,       e_a0 ? e_data : 32'h0);
        check({tag, ".m1_ack"},  32'(bus.m1_ack_o),   32'(e_a1));
        check({tag, ".m1_err"},  32'(bus.m1_error_o), 32'(e_a1 && e_err));
        check({tag, ".m1_data"}, bus.m1_data_o,       e_a1 ? e_data : 32'h0);
    endtask

    vec_t tbl[15];

    // Reference-model state for the random phase.
    bit          m_req  [2];
    bit          m_hold [2];
    logic [31:0] m_addr [2];
    bit          x_busy;
    bit          x_owner;
    bit          x_prio;
    int          x_cnt;
    int          x_lat;
    logic [31:0] x_addr;

    initial begin
        bus.m0_req_i = 1'b0; bus.m0_addr_i = '0; bus.m1_req_i = 1'b0; bus.m1_addr_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_error_i = 1'b0; bus.mem_data_i = '0;

        // Contention after reset (with m1 error), then a single m0 fetch acked in BUSY cycle 3.
        tbl[0]  = v(1, 0, A_M0, 0, 0, 0, 32'h0,         0, 0, 0,    0, 0, 0, 32'h0);
        tbl[1]  = v(0, 1, A_M0, 1, 0, 0, 32'h0,         0, 0, 0,    0, 0, 0, 32'h0);
        tbl[2]  = v(0, 1, A_M0, 1, 1, 0, 32'h0000_0A01, 1, 0, A_M0, 1, 0, 0, 32'h0000_0A01);
        tbl[3]  = v(0, 1, A_M0, 1, 0, 0, 32'h0,         0, 0, 0,    0, 0, 0, 32'h0);
        tbl[4]  = v(0, 1, A_M0, 1, 1, 1, 32'h0000_0B02, 1, 1, A_M1, 0, 1, 1, 32'h0000_0B02);
        tbl[5]  = v(0, 1, A_M0, 1, 0, 0, 32'h0,         0, 1, 0,    0, 0, 0, 32'h0);
        tbl[6]  = v(0, 1, A_M0, 1, 1, 0, 32'h0000_0C03, 1, 0, A_M0, 1, 0, 0, 32'h0000_0C03);
        tbl[7]  = v(0, 1, A_M0, 1, 0, 0, 32'h0,         0, 0, 0,    0, 0, 0, 32'h0);
        tbl[8]  = v(0, 1, A_M0, 1, 1, 0, 32'h0000_0D04, 1, 1, A_M1, 0, 1, 0, 32'h0000_0D04);
        tbl[9]  = v(0, 0, A_S,  0, 0, 0, 32'h0,         0, 1, 0,    0, 0, 0, 32'h0);
        tbl[10] = v(0, 1, A_S,  0, 0, 0, 32'h0,         0, 1, 0,    0, 0, 0, 32'h0);
        tbl[11] = v(0, 1, A_S,  0, 0, 0, 32'h0,         1, 0, A_S,  0, 0, 0, 32'h0);
        tbl[12] = v(0, 1, A_S,  0, 0, 0, 32'h0,         1, 0, A_S,  0, 0, 0, 32'h0);
        tbl[13] = v(0, 1, A_S,  0, 1, 0, 32'hDEAD_BEEF, 1, 0, A_S,  1, 0, 0, 32'hDEAD_BEEF);
        tbl[14] = v(0, 0, A_S,  0, 0, 0, 32'h0,         0, 0, 0,    0, 0, 0, 32'h0);

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset.mem_addr", bus.mem_addr_o, 32'h0);
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rst, tbl[i].r0, tbl[i].a0, tbl[i].r1, A_M1,
                  tbl[i].ack, tbl[i].err, tbl[i].data);
            check_outs($sformatf("tbl%0d", i), tbl[i].e_mr, tbl[i].e_gnt, tbl[i].e_addr,
                       tbl[i].e_a0, tbl[i].e_a1, tbl[i].e_err, tbl[i].e_data);
        end

        // Timeout: memory never answers, forced error in BUSY cycle TMO, then a stray ack.
        cycle(0, 1, 32'h0000_4440, 0, 0, 0, 0, 0);
        check_outs("tmo.idle", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= TMO; k++) begin
            cycle(0, 1, 32'h0000_4440, 0, 0, 0, 0, 0);
            check_outs($sformatf("tmo.busy%0d", k), 1, 0, 32'h0000_4440,
                       k == TMO, 0, 1, 32'h0);
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h5555_5555);
        check_outs("tmo.stray", 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check_outs("tmo.after", 0, 0, 0, 0, 0, 0, 0);

        // Reset in the second BUSY cycle abandons the transaction; m0 wins first afterwards.
        cycle(0, 1, 32'h0000_7770, 0, 0, 0, 0, 0);
        check_outs("rstb.idle", 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h0000_7770, 0, 0, 0, 0, 0);
        check_outs("rstb.busy1", 1, 0, 32'h0000_7770, 0, 0, 0, 0);
        cycle(1, 1, 32'h0000_7770, 0, 0, 1, 0, 32'hCAFE_F00D);
        check_outs("rstb.busy2", 1, 0, 32'h0000_7770, 0, 0, 0, 0);
        cycle(0, 1, A_M0, 1, A_M1, 0, 0, 0);
        check_outs("rstb.after", 0, 0, 0, 0, 0, 0, 0);
        check("rstb.mem_addr", bus.mem_addr_o, 32'h0);
        cycle(0, 1, A_M0, 1, A_M1, 1, 0, 32'h1234_5678);
        check_outs("rstb.first", 1, 0, A_M0, 1, 0, 0, 32'h1234_5678);

        // Random traffic against the transaction-level model.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            m_req[m] = 0; m_hold[m] = 0; m_addr[m] = '0;
        end
        x_busy = 0; x_owner = 0; x_prio = 0; x_cnt = 0; x_lat = 0; x_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            bit          ack, err, resp;
            logic [31:0] data;
            ack  = x_busy && (x_cnt == x_lat);
            err  = ack ? 1'($urandom_range(0, 1)) : 1'b0;
            data = ack ? $urandom : 32'h0;
            cycle(0, m_req[0], m_addr[0], m_req[1], m_addr[1], ack, err, data);
            resp = x_busy && (ack || x_cnt == TMO - 1);
            check_outs($sformatf("rnd%0d", i), x_busy, x_owner, x_addr,
                       resp && !x_owner, resp && x_owner, ack ? err : 1'b1,
                       ack ? data : 32'h0);

            if (x_busy) begin
                if (resp) begin
                    x_busy          = 0;
                    m_req[x_owner]  = 0;
                    m_hold[x_owner] = 0;
                end else begin
                    x_cnt++;
                    if (m_req[x_owner] && $urandom_range(0, 15) == 0) begin
                        m_req[x_owner]  = 0;
                        m_hold[x_owner] = 1;
                    end
                end
            end else if (m_req[0] || m_req[1]) begin
                x_owner = (m_req[0] && m_req[1]) ? x_prio : m_req[1];
                x_prio  = !x_owner;
                x_busy  = 1;
                x_cnt   = 0;
                x_lat   = int'($urandom_range(0, TMO + 1));
                x_addr  = m_addr[x_owner];
            end
            for (int m = 0; m < 2; m++) begin
                if (!m_req[m] && !m_hold[m] && $urandom_range(0, 2) == 0) begin
                    m_req[m]  = 1;
                    m_addr[m] = $urandom;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
